twisted_ring_counter: RTL
=========================

Name: twisted_ring_counter

Overview:
- Parametrised shift-register counter for sequencing and phase generation; successor to the fixed 4-bit Johnson counter.
- Runs in Johnson (twisted-ring, 2*WIDTH states) or ring (one-hot, WIDTH states) mode, counting up or down, with enable and synchronous load.
- Adds illegal-state self-correction, a decoded phase index and a wrap pulse.
- Sits beside the timing and sequencing blocks and drives strobes and phase selects.

Parameters:
- WIDTH, 4, number of register bits; must be at least 2.
- INIT_MODE, 0, mode whose base state is loaded at reset (0 = Johnson, 1 = ring).
- PW, $clog2(2*WIDTH), width of the phase output; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  advance one step per clock when high
- mode  input  1  0 = Johnson, 1 = ring
- dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB)
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- q  output  WIDTH  counter register
- phase  output  PW  decoded step index of q
- wrap  output  1  one-cycle registered pulse on sequence wrap
- illegal  output  1  combinational; high when q is not a legal state for the current mode

Behaviour:
- Reset (async, active-high):
  - q = 0 when INIT_MODE = 0; q = 1 (LSB set) when INIT_MODE = 1.
  - wrap = 0.
- Base state: Johnson = all zeros; ring = LSB-only.
- Next-state priority on each rising edge of clk (reset overrides all):
  - 1. load: q <= load_val, wrap <= 0.
  - 2. illegal: q <= base state of the current mode, wrap <= 0. This applies regardless of en.
  - 3. en:
    - Johnson up: q <= {q[W-2:0], ~q[W-1]}.
    - Johnson down: q <= {~q[0], q[W-1:1]}.
    - Ring up: q <= {q[W-2:0], q[W-1]}.
    - Ring down: q <= {q[0], q[W-1:1]}.
  - 4. otherwise: q holds, wrap <= 0.
- Legality:
  - Johnson: at most one i in 0..W-2 with q[i] != q[i+1].
  - Ring: popcount(q) == 1.
- phase (combinational from q):
  - Johnson: if q[0] = 1 or q = 0, phase = popcount(q); else phase = 2W - popcount(q). Range is 0..2W-1.
  - Ring: phase = index of the set bit. Range is 0..W-1.
  - phase = 0 whenever illegal = 1.
- wrap is set only by an en step:
  - Up: the step moves q from the last phase (Johnson 2W-1, ring W-1) to phase 0.
  - Down: the step moves q from phase 0 to the last phase.
  - wrap is high in the cycle in which the new q is visible; latency 1 clock, the same edge that updates q.
- Loaded values are not checked at load time. An illegal load_val is corrected one clock later and illegal is high for that one cycle.
- A mode change takes effect immediately. If q is illegal in the new mode it is corrected on the next edge. Example: Johnson 0011 under ring mode becomes 0001.
- A dir change takes effect on the next enabled step. No state is lost.
- load and en together: load wins and no wrap is produced.
- Reset mid-sequence: q returns to the reset value asynchronously; a pending wrap is cleared.

Decomposition:
- Package twisted_ring_pkg holds:
  - mode constants MODE_JOHNSON = 1'b0 and MODE_RING = 1'b1;
  - direction constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
- One sub-module, trc_decode: purely combinational, parameterised by WIDTH. It takes q and mode and produces illegal and phase. The top instantiates it once and reuses its outputs to compute wrap.

Test Plan:
- WIDTH=4, INIT_MODE=0, Johnson up, en=1 for 9 clocks:
  - q steps 0001,0011,0111,1111,1110,1100,1000,0000,0001;
  - phase steps 1..7,0,1;
  - wrap high only with the 0000 state.
- Johnson down from 0000:
  - q steps 1000,1100,1110,1111,0111,0011,0001,0000;
  - wrap high with 1000; phase 7 on that cycle.
- Ring mode, mode=1:
  - load 0100 -> phase 2.
  - Up for 3 steps -> 1000, 0001 (wrap=1), 0010.
  - en=0 for 5 clocks -> q holds at 0010, wrap=0.
- Illegal recovery:
  - Johnson: load 0101 -> illegal=1 and phase=0 for one cycle, then q=0000 even with en=0.
  - Ring: load 0000 -> q=0001 on the next clock.
- Mode switch and priority:
  - Johnson q=0011, set mode=1 -> next q=0001.
  - load=1 and en=1 with load_val=0100 in ring mode -> q=0100, wrap=0.
- Reset and width:
  - Assert reset mid-sequence between clock edges -> q=0000 immediately, wrap=0.
  - WIDTH=5 Johnson full cycle -> 10 distinct states, wrap period 10 clocks.

Source files
------------

// File: rtl/twisted_ring_pkg.sv
// twisted_ring_pkg: mode and direction encodings shared by the twisted ring counter files
package twisted_ring_pkg;
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
endpackage

// File: rtl/trc_decode.sv
// trc_decode: combinational legality check and phase decode of a Johnson/ring counter value
//   q       in  counter value
//   mode    in  0 = Johnson, 1 = ring
//   illegal out q is not a reachable state in the given mode
//   phase   out step index of q, 0 when illegal
module trc_decode
  import twisted_ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PW = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             illegal,
  output logic [PW-1:0]    phase
);
  localparam int CW = PW + 1;
  logic [CW-1:0] pop, edges;
  logic [PW-1:0] idx;
  always_comb begin
    pop = '0;
    edges = '0;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop += CW'(q[i]);
      if (q[i]) idx = PW'(i);
    end
    for (int i = 0; i < WIDTH - 1; i++) edges += CW'(q[i] ^ q[i+1]);
    illegal = mode == MODE_RING ? pop != CW'(1) : edges > CW'(1);
    // Johnson: filling half counts ones, draining half counts down from 2W
    phase = illegal ? '0 :
            mode == MODE_RING ? idx :
            (q[0] || q == '0) ? PW'(pop) : PW'(2*WIDTH) - PW'(pop);
  end
endmodule

// File: rtl/twisted_ring_counter.sv
// twisted_ring_counter: Johnson/ring shift counter with self-correction, phase decode and wrap pulse
//   clk, reset (async, active-high); en advances; mode 0 Johnson / 1 ring; dir 0 up / 1 down
//   load/load_val synchronous load; q counter; phase step index; wrap registered wrap pulse;
//   illegal combinational flag for a q that is not legal in the current mode
module twisted_ring_counter
  import twisted_ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int INIT_MODE = 0,
  parameter int PW = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);
  logic [WIDTH-1:0] q_d, q_q, base, step;
  logic [PW-1:0] last;
  logic wrap_d, wrap_q;
  trc_decode #(.WIDTH(WIDTH), .PW(PW)) u_dec (
    .q(q_q),
    .mode(mode),
    .illegal(illegal),
    .phase(phase)
  );
  always_comb begin
    base = mode == MODE_RING ? WIDTH'(1) : '0;
    step = mode == MODE_RING ?
           (dir == DIR_UP ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} : {q_q[0], q_q[WIDTH-1:1]}) :
           (dir == DIR_UP ? {q_q[WIDTH-2:0], ~q_q[WIDTH-1]} : {~q_q[0], q_q[WIDTH-1:1]});
    last = mode == MODE_RING ? PW'(WIDTH - 1) : PW'(2*WIDTH - 1);
    q_d = load ? load_val : illegal ? base : en ? step : q_q;
    // only a legal enabled step can cross the last/first phase boundary
    wrap_d = !load && !illegal && en && (dir == DIR_UP ? phase == last : phase == '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= INIT_MODE == 1 ? WIDTH'(1) : '0;
      wrap_q <= 1'b0;
    end else begin
      q_q <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign q = q_q;
  assign wrap = wrap_q;
endmodule
